// File: rtl/vec_csr_pkg.sv
// Shared types for the vector configuration CSR block:
// vtype layout, LMUL/SEW encodings, AVL modes and FSM states.
package vec_csr_pkg;

  localparam int CSR_XLEN = 32;
  localparam int CSR_VLEN = 512;
  localparam int CSR_ELEN = 32;

  typedef enum logic [2:0] {
    LMUL_1    = 3'd0,
    LMUL_2    = 3'd1,
    LMUL_4    = 3'd2,
    LMUL_8    = 3'd3,
    LMUL_RSVD = 3'd4,
    LMUL_F8   = 3'd5,
    LMUL_F4   = 3'd6,
    LMUL_F2   = 3'd7
  } vlmul_e;

  typedef enum logic [2:0] {
    SEW_8  = 3'd0,
    SEW_16 = 3'd1,
    SEW_32 = 3'd2,
    SEW_64 = 3'd3
  } vsew_e;

  // vsew stays raw: encodings 4..7 are reserved but must be observable
  typedef struct packed {
    logic                vill;
    logic [CSR_XLEN-10:0] reserved;
    logic                vma;
    logic                vta;
    logic [2:0]          vsew;
    vlmul_e              vlmul;
  } vtype_t;

  typedef enum logic [1:0] {
    AVL_REG  = 2'd0,
    AVL_MAX  = 2'd1,
    AVL_KEEP = 2'd2,
    AVL_RSVD = 2'd3
  } avl_mode_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    COMMIT = 2'd2,
    WB     = 2'd3
  } csr_state_e;

  localparam vtype_t VILL_VTYPE = '{
    vill:     1'b1,
    reserved: '0,
    vma:      1'b0,
    vta:      1'b0,
    vsew:     3'd0,
    vlmul:    LMUL_1
  };

endpackage

// File: rtl/vec_csr_regfile_vlmax.sv
// Combinational vtype legality check and VLMAX computation.
// VLMAX = VLEN/SEW scaled by LMUL; forced to 0 for an illegal vtype.
module vec_vlmax_calc
  import vec_csr_pkg::*;
#(
  parameter int VLEN = CSR_VLEN,
  parameter int ELEN = CSR_ELEN
) (
  input  vtype_t                vtype_i,
  output logic                  vill_o,
  output logic [$clog2(VLEN):0] vlmax_o
);

  localparam int VW = $clog2(VLEN) + 1;

  logic [2:0]    sew;
  logic [2:0]    lmul;
  logic [31:0]   sew_bits;
  logic [31:0]   elen_c;
  logic [3:0]    frac_sh;
  logic          frac;
  logic [VW-1:0] base;
  logic          unused_fields;

  assign unused_fields = ^{vtype_i.vill, vtype_i.vma, vtype_i.vta};

  always_comb begin
    sew      = vtype_i.vsew;
    lmul     = vtype_i.vlmul;
    sew_bits = 32'd8 << sew;
    elen_c   = 32'(ELEN);
    frac     = lmul[2] & (lmul != LMUL_RSVD);
    frac_sh  = 4'd8 - {1'b0, lmul};
    // fractional LMUL needs SEW <= ELEN * LMUL
    vill_o   = (|vtype_i.reserved)
             | (lmul == LMUL_RSVD)
             | sew[2]
             | (sew_bits > elen_c)
             | (frac & (sew_bits > (elen_c >> frac_sh)));
    base     = VW'(VLEN) >> ({1'b0, sew} + 4'd3);
    if (vill_o)
      vlmax_o = '0;
    else if (frac)
      vlmax_o = base >> frac_sh;
    else
      vlmax_o = base << lmul;
  end

endmodule

// File: rtl/vec_csr_regfile.sv
// Vector configuration CSRs (vtype/vl/vstart) executing vset{i}vl{i}
// commits through an IDLE->CALC->COMMIT->WB sequence.
module vec_csr_regfile
  import vec_csr_pkg::*;
#(
  parameter int XLEN = CSR_XLEN,
  parameter int VLEN = CSR_VLEN,
  parameter int ELEN = CSR_ELEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [XLEN-1:0] scalar1,
  input  logic [XLEN-1:0] scalar2,
  input  logic [1:0]      avl_mode,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] csr_vtype,
  output logic [XLEN-1:0] csr_vl,
  output logic [XLEN-1:0] csr_vlmax,
  output logic            csr_vill,
  input  logic            vstart_wr_en,
  input  logic [XLEN-1:0] vstart_wr_data,
  input  logic            inst_done,
  output logic [XLEN-1:0] csr_vstart
);

  localparam int VW = $clog2(VLEN) + 1;

  csr_state_e      state_q, state_d;
  logic            cfg_ready_q, cfg_ready_d;
  logic [XLEN-1:0] s1_q, s1_d;
  vtype_t          req_vtype_q, req_vtype_d;
  avl_mode_e       mode_q, mode_d;
  vtype_t          calc_vtype_q, calc_vtype_d;
  logic [VW-1:0]   vlmax_q, vlmax_d;
  vtype_t          csr_vtype_q, csr_vtype_d;
  logic [XLEN-1:0] csr_vl_q, csr_vl_d;
  logic [VW-1:0]   csr_vlmax_q, csr_vlmax_d;
  logic [XLEN-1:0] vstart_q, vstart_d;
  logic            wb_valid_q, wb_valid_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;

  logic            calc_vill;
  logic [VW-1:0]   calc_vlmax;
  logic [XLEN-1:0] vlmax_x;
  logic [XLEN-1:0] new_vl;

  vec_vlmax_calc #(
    .VLEN (VLEN),
    .ELEN (ELEN)
  ) u_vlmax (
    .vtype_i (req_vtype_q),
    .vill_o  (calc_vill),
    .vlmax_o (calc_vlmax)
  );

  // an illegal vtype has vlmax_q == 0, so every mode yields vl = 0
  always_comb begin
    vlmax_x = XLEN'(vlmax_q);
    unique case (mode_q)
      AVL_MAX:  new_vl = vlmax_x;
      AVL_KEEP: new_vl = (csr_vl_q < vlmax_x) ? csr_vl_q : vlmax_x;
      default:  new_vl = (s1_q <= vlmax_x) ? s1_q : vlmax_x;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cfg_ready_d  = cfg_ready_q;
    s1_d         = s1_q;
    req_vtype_d  = req_vtype_q;
    mode_d       = mode_q;
    calc_vtype_d = calc_vtype_q;
    vlmax_d      = vlmax_q;
    csr_vtype_d  = csr_vtype_q;
    csr_vl_d     = csr_vl_q;
    csr_vlmax_d  = csr_vlmax_q;
    wb_valid_d   = wb_valid_q;
    wb_data_d    = wb_data_q;
    vstart_d     = vstart_q;
    if (vstart_wr_en) vstart_d = vstart_wr_data;
    if (inst_done)    vstart_d = '0;
    case (state_q)
      IDLE: begin
        if (cfg_valid) begin
          s1_d        = scalar1;
          req_vtype_d = vtype_t'(scalar2);
          mode_d      = avl_mode_e'(avl_mode);
          cfg_ready_d = 1'b0;
          state_d     = CALC;
        end
      end
      CALC: begin
        calc_vtype_d      = req_vtype_q;
        calc_vtype_d.vill = 1'b0;
        if (calc_vill) calc_vtype_d = VILL_VTYPE;
        vlmax_d = calc_vlmax;
        state_d = COMMIT;
      end
      COMMIT: begin
        csr_vtype_d = calc_vtype_q;
        csr_vl_d    = new_vl;
        csr_vlmax_d = vlmax_q;
        vstart_d    = '0;
        wb_data_d   = new_vl;
        wb_valid_d  = 1'b1;
        state_d     = WB;
      end
      WB: begin
        if (wb_ready) begin
          wb_valid_d  = 1'b0;
          cfg_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cfg_ready_q  <= 1'b1;
      s1_q         <= '0;
      req_vtype_q  <= '0;
      mode_q       <= AVL_REG;
      calc_vtype_q <= VILL_VTYPE;
      vlmax_q      <= '0;
      csr_vtype_q  <= VILL_VTYPE;
      csr_vl_q     <= '0;
      csr_vlmax_q  <= '0;
      vstart_q     <= '0;
      wb_valid_q   <= 1'b0;
      wb_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      cfg_ready_q  <= cfg_ready_d;
      s1_q         <= s1_d;
      req_vtype_q  <= req_vtype_d;
      mode_q       <= mode_d;
      calc_vtype_q <= calc_vtype_d;
      vlmax_q      <= vlmax_d;
      csr_vtype_q  <= csr_vtype_d;
      csr_vl_q     <= csr_vl_d;
      csr_vlmax_q  <= csr_vlmax_d;
      vstart_q     <= vstart_d;
      wb_valid_q   <= wb_valid_d;
      wb_data_q    <= wb_data_d;
    end
  end

  assign cfg_ready  = cfg_ready_q;
  assign wb_valid   = wb_valid_q;
  assign wb_data    = wb_data_q;
  assign csr_vtype  = csr_vtype_q;
  assign csr_vill   = csr_vtype_q.vill;
  assign csr_vl     = csr_vl_q;
  assign csr_vlmax  = XLEN'(csr_vlmax_q);
  assign csr_vstart = vstart_q;

endmodule

// File: tb/tb_vec_csr_regfile.sv
// Scoreboard bench for vec_csr_regfile: requests push expected results,
// a negedge monitor pops and compares whenever wb_valid is presented.
module tb_vec_csr_regfile;

  localparam int XLEN = 32;
  localparam int VLEN = 512;
  localparam int ELEN = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [31:0] scalar1 = '0;
  logic [31:0] scalar2 = '0;
  logic [1:0]  avl_mode = '0;
  logic        wb_valid;
  logic        wb_ready = 1'b1;
  logic [31:0] wb_data;
  logic [31:0] csr_vtype;
  logic [31:0] csr_vl;
  logic [31:0] csr_vlmax;
  logic        csr_vill;
  logic        vstart_wr_en = 1'b0;
  logic [31:0] vstart_wr_data = '0;
  logic        inst_done = 1'b0;
  logic [31:0] csr_vstart;

  vec_csr_regfile #(.XLEN(XLEN), .VLEN(VLEN), .ELEN(ELEN)) dut (
    .clk            (clk),
    .reset          (reset),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .scalar1        (scalar1),
    .scalar2        (scalar2),
    .avl_mode       (avl_mode),
    .wb_valid       (wb_valid),
    .wb_ready       (wb_ready),
    .wb_data        (wb_data),
    .csr_vtype      (csr_vtype),
    .csr_vl         (csr_vl),
    .csr_vlmax      (csr_vlmax),
    .csr_vill       (csr_vill),
    .vstart_wr_en   (vstart_wr_en),
    .vstart_wr_data (vstart_wr_data),
    .inst_done      (inst_done),
    .csr_vstart     (csr_vstart)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [31:0] vtype;
    logic [31:0] vl;
    logic [31:0] vlmax;
    int          vcyc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [31:0] model_vl = '0;
  bit          bp_rand = 1'b0;
  logic        bp_force = 1'b1;
  bit          seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    wb_ready = bp_rand ? ($urandom_range(0, 3) != 0) : bp_force;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: LMUL as a fraction num/den, VLMAX = VLEN*LMUL/SEW
  function automatic exp_t model(input logic [31:0] s1, input logic [31:0] s2,
                                 input logic [1:0] mode,
                                 input logic [31:0] old_vl);
    exp_t        e;
    int          lm, sw, sew, num, den;
    bit          ill;
    logic [31:0] vmax;
    lm  = int'(s2[2:0]);
    sw  = int'(s2[5:3]);
    sew = 8 << sw;
    num = 1;
    den = 1;
    if (lm < 4) num = 1 << lm;
    else if (lm > 4) den = 1 << (8 - lm);
    ill = (s2[30:8] != 0) || (lm == 4) || (sw > 3) || (sew > ELEN)
       || (sew * den > ELEN * num);
    vmax = ill ? 32'd0 : 32'((VLEN * num) / (sew * den));
    if (ill) e.vl = 32'd0;
    else if (mode == 2'd1) e.vl = vmax;
    else if (mode == 2'd2) e.vl = (old_vl < vmax) ? old_vl : vmax;
    else e.vl = (s1 < vmax) ? s1 : vmax;
    e.data  = e.vl;
    e.vlmax = vmax;
    e.vtype = ill ? 32'h8000_0000 : {1'b0, s2[30:0]};
    e.vcyc  = 0;
    return e;
  endfunction

  always @(negedge clk) begin
    if (reset || !wb_valid) begin
      seen = 1'b0;
    end else begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_wb: got wb_data 0x%08h, expected none",
                 wb_data);
      end else if (!seen) begin
        seen = 1'b1;
        chk("wb_latency", 32'(cyc), 32'(exp_q[0].vcyc));
        chk("wb_data", wb_data, exp_q[0].data);
        chk("csr_vtype", csr_vtype, exp_q[0].vtype);
        chk("csr_vill", 32'(csr_vill), {31'd0, exp_q[0].vtype[31]});
        chk("csr_vl", csr_vl, exp_q[0].vl);
        chk("csr_vlmax", csr_vlmax, exp_q[0].vlmax);
        chk("vstart_commit", csr_vstart, 32'd0);
        chk("cfg_ready_wb", 32'(cfg_ready), 32'd0);
      end else begin
        chk("wb_data_hold", wb_data, exp_q[0].data);
        chk("cfg_ready_hold", 32'(cfg_ready), 32'd0);
      end
      if (wb_ready) begin
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        seen = 1'b0;
      end
    end
  end

  task automatic send(input logic [31:0] s1, input logic [31:0] s2,
                      input logic [1:0] mode);
    exp_t e;
    int   n;
    @(negedge clk);
    scalar1   = s1;
    scalar2   = s2;
    avl_mode  = mode;
    cfg_valid = 1'b1;
    n = 0;
    while (!cfg_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cfg_ready) begin
      checks++;
      failures++;
      $display("FAIL cfg_accept_timeout: got cfg_ready 0, expected 1");
      cfg_valid = 1'b0;
      return;
    end
    e = model(s1, s2, mode, model_vl);
    e.vcyc = cyc + 3;
    model_vl = e.vl;
    exp_q.push_back(e);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d pending, expected 0",
               exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic wait_wb();
    int n;
    n = 0;
    while (!wb_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("wb_wait", 32'(wb_valid), 32'd1);
  endtask

  task automatic reset_check(input string tag);
    reset = 1'b1;
    #1;
    chk({tag, "_wb_valid"}, 32'(wb_valid), 32'd0);
    chk({tag, "_wb_data"}, wb_data, 32'd0);
    chk({tag, "_cfg_ready"}, 32'(cfg_ready), 32'd1);
    chk({tag, "_vtype"}, csr_vtype, 32'h8000_0000);
    chk({tag, "_vill"}, 32'(csr_vill), 32'd1);
    chk({tag, "_vl"}, csr_vl, 32'd0);
    chk({tag, "_vlmax"}, csr_vlmax, 32'd0);
    chk({tag, "_vstart"}, csr_vstart, 32'd0);
    exp_q.delete();
    model_vl = '0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk({tag, "_cfg_ready_rel"}, 32'(cfg_ready), 32'd1);
    chk({tag, "_wb_valid_rel"}, 32'(wb_valid), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ill_v[4];
    logic [31:0] s1, s2, rsv;
    logic [2:0]  lm, sw;
    logic        ta, ma;

    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_vill", 32'(csr_vill), 32'd1);
    chk("rst_vl", csr_vl, 32'd0);
    chk("rst_vtype", csr_vtype, 32'h8000_0000);
    chk("rst_vlmax", csr_vlmax, 32'd0);
    chk("rst_vstart", csr_vstart, 32'd0);
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);

    send(32'd10, 32'h10, 2'd0);
    drain();
    send(32'd1000, 32'h03, 2'd0);
    send(32'd0, 32'h07, 2'd1);
    drain();

    ill_v[0] = 32'h04;
    ill_v[1] = 32'h18;
    ill_v[2] = 32'h17;
    ill_v[3] = 32'h100;
    for (int i = 0; i < 4; i++) send(32'd5, ill_v[i], 2'd0);
    drain();

    send(32'd16, 32'h10, 2'd0);
    send(32'd0, 32'h11, 2'd2);
    send(32'd0, 32'h17, 2'd2);
    drain();

    // writeback stall with a concurrent vstart write and a stray request
    bp_force       = 1'b0;
    vstart_wr_data = 32'd7;
    vstart_wr_en   = 1'b1;
    send(32'd3, 32'h10, 2'd0);
    wait_wb();
    repeat (2) @(negedge clk);
    scalar1   = 32'd99;
    scalar2   = 32'h03;
    avl_mode  = 2'd0;
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    repeat (2) @(negedge clk);
    bp_force = 1'b1;
    drain();
    repeat (3) @(negedge clk);
    chk("vstart_idle_wr", csr_vstart, 32'd7);
    chk("vl_after_stall", csr_vl, 32'd3);
    vstart_wr_data = 32'd9;
    inst_done      = 1'b1;
    @(negedge clk);
    chk("vstart_inst_done", csr_vstart, 32'd0);
    inst_done = 1'b0;
    @(negedge clk);
    chk("vstart_wr_9", csr_vstart, 32'd9);
    vstart_wr_en = 1'b0;

    send(32'd20, 32'h10, 2'd0);
    reset_check("rst_calc");
    send(32'd7, 32'h08, 2'd0);
    drain();
    bp_force = 1'b0;
    send(32'd40, 32'h10, 2'd0);
    wait_wb();
    @(negedge clk);
    reset_check("rst_wb");
    bp_force = 1'b1;

    bp_rand = 1'b1;
    for (int i = 0; i < 60; i++) begin
      lm  = 3'($urandom_range(0, 7));
      sw  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7))
                                        : 3'($urandom_range(0, 3));
      ta  = 1'($urandom_range(0, 1));
      ma  = 1'($urandom_range(0, 1));
      rsv = ($urandom_range(0, 9) == 0) ? (32'd1 << $urandom_range(8, 30))
                                        : 32'd0;
      s2  = rsv | {24'd0, ma, ta, sw, lm};
      case ($urandom_range(0, 3))
        0:       s1 = 32'($urandom_range(0, 40));
        1:       s1 = 32'($urandom_range(0, 600));
        2:       s1 = 32'hFFFF_FFFF;
        default: s1 = $urandom;
      endcase
      send(s1, s2, 2'($urandom_range(0, 3)));
    end
    drain();
    bp_rand = 1'b0;
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
